// File: rtl/s15850_pred_pkg.sv
// Shared types and helpers for the s15850 predicate pipeline.
// Optional parity feature macro: S15850_PRED_PARITY_EN (used by s15850_pred_lane).
package s15850_pred_pkg;

    // Channel class derived from the 4-bit state code.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } pred_class_e;

    // Bit positions inside each channel's 3-bit cfg slice {pol, en_hi, en_lo}.
    localparam int unsigned CFG_EN_LO = 0;
    localparam int unsigned CFG_EN_HI = 1;
    localparam int unsigned CFG_POL   = 2;
    localparam int unsigned CFG_W     = 3;

    function automatic pred_class_e classify(input logic [3:0] code);
        if (code == 4'd0) begin
            return IDLE;
        end else if (code[3]) begin
            return HI;
        end else begin
            return LO;
        end
    endfunction

endpackage

// File: rtl/s15850_pred_lane.sv
// One channel of the predicate pipeline: stage-1 classification, stage-2
// predicate and a saturating hit counter. Pipeline control lives in the top.
// Macro S15850_PRED_PARITY_EN adds field parity and gates the HI match on it.
module s15850_pred_lane
    import s15850_pred_pkg::*;
#(
    parameter int unsigned FW    = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             s1_load,
    input  logic             s2_load,
    input  logic             accept,
    input  logic             clr_cnt,
    input  logic [3:0]       code,
    input  logic [FW-1:0]    field,
    input  logic [CFG_W-1:0] cfg,
    output logic             hit,
    output logic             par,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pred_class_e s1_class;
    logic        s1_fz;
    logic        s1_fo;
    logic        s1_par;
    logic        s1_pol;
    logic        s1_en_hi;
    logic        s1_en_lo;
    logic        field_par;
    logic        match;

`ifdef S15850_PRED_PARITY_EN
    assign field_par = ^field;
`else
    assign field_par = 1'b0;
`endif

    // Stage 1: capture class, field flags and config of the accepted beat.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            s1_class <= IDLE;
            s1_fz    <= 1'b0;
            s1_fo    <= 1'b0;
            s1_par   <= 1'b0;
            s1_pol   <= 1'b0;
            s1_en_hi <= 1'b0;
            s1_en_lo <= 1'b0;
        end else if (s1_load) begin
            s1_class <= classify(code);
            s1_fz    <= (field == '0);
            s1_fo    <= (&field);
            s1_par   <= field_par;
            s1_pol   <= cfg[CFG_POL];
            s1_en_hi <= cfg[CFG_EN_HI];
            s1_en_lo <= cfg[CFG_EN_LO];
        end
    end

    // Predicate from the stage-1 flags; s1_par is constant 0 without parity.
    always_comb begin
        match = 1'b0;
        unique case (s1_class)
            HI:      match = s1_fo & s1_en_hi & ~s1_par;
            LO:      match = s1_fz & s1_en_lo;
            default: match = 1'b0;
        endcase
    end

    // Stage 2: result register, held while the output is stalled.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            hit <= 1'b0;
            par <= 1'b0;
        end else if (s2_load) begin
            hit <= match ^ s1_pol;
            par <= s1_par;
        end
    end

    // Saturating hit counter; clear takes priority over a coincident acceptance.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (accept && hit && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/s15850_pred_pipe.sv
// Two-stage valid/ready predicate pipeline over CH channels with per-channel
// saturating hit counters and a sticky any_hit flag.
// Optional feature macro: S15850_PRED_PARITY_EN (field parity on par output).
module s15850_pred_pipe
    import s15850_pred_pkg::*;
#(
    parameter int unsigned FW    = 4,
    parameter int unsigned CH    = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*4-1:0]     code,
    input  logic [CH*FW-1:0]    field,
    input  logic [CH*CFG_W-1:0] cfg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH-1:0]       hit,
    output logic [CH-1:0]       par,
    input  logic                clr_cnt,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                any_hit
);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic in_fire;
    logic s2_fill;
    logic accept;

    // Handshake: in_ready is combinational from out_ready through s2_adv.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
        in_fire  = in_valid && in_ready;
        s2_fill  = s1_valid && s2_adv;
        accept   = s2_valid && out_ready;
    end

    assign out_valid = s2_valid;

    // Stage valid flags.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Sticky any_hit; clear wins over a coincident acceptance.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            any_hit <= 1'b0;
        end else if (clr_cnt) begin
            any_hit <= 1'b0;
        end else if (accept && (|hit)) begin
            any_hit <= 1'b1;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        s15850_pred_lane #(
            .FW   (FW),
            .CNT_W(CNT_W)
        ) u_lane (
            .CK     (CK),
            .RST    (RST),
            .s1_load(in_fire),
            .s2_load(s2_fill),
            .accept (accept),
            .clr_cnt(clr_cnt),
            .code   (code[4*c +: 4]),
            .field  (field[FW*c +: FW]),
            .cfg    (cfg[CFG_W*c +: CFG_W]),
            .hit    (hit[c]),
            .par    (par[c]),
            .cnt    (cnt[CNT_W*c +: CNT_W])
        );
    end

endmodule

// File: tb/tb_s15850_pred_pipe.sv
// Self-checking bench for s15850_pred_pipe: randomized and directed stimulus
// against a transaction-level model (queue of in-flight beats plus counters).
module tb_s15850_pred_pipe;

    localparam int FW    = 4;
    localparam int CH    = 2;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                CK = 1'b0;
    logic                RST;
    logic                in_valid;
    logic                in_ready;
    logic [CH*4-1:0]     code;
    logic [CH*FW-1:0]    field;
    logic [CH*3-1:0]     cfg;
    logic                out_valid;
    logic                out_ready;
    logic [CH-1:0]       hit;
    logic [CH-1:0]       par;
    logic                clr_cnt;
    logic [CH*CNT_W-1:0] cnt;
    logic                any_hit;

    s15850_pred_pipe #(
        .FW   (FW),
        .CH   (CH),
        .CNT_W(CNT_W)
    ) dut (
        .CK       (CK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .code     (code),
        .field    (field),
        .cfg      (cfg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .hit      (hit),
        .par      (par),
        .clr_cnt  (clr_cnt),
        .cnt      (cnt),
        .any_hit  (any_hit)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [CH-1:0] h;
        logic [CH-1:0] p;
        int            e;
    } beat_t;

    beat_t q[$];
    int    cnt_m[CH];
    bit    any_m;
    int    edge_cnt = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    n_out = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-channel result straight from the classification rules.
    function automatic void predict(input logic [CH*4-1:0] cd, input logic [CH*FW-1:0] fd,
                                    input logic [CH*3-1:0] cf, output logic [CH-1:0] h,
                                    output logic [CH-1:0] p);
        logic [3:0]    k;
        logic [FW-1:0] f;
        logic [2:0]    g;
        int            ones;
        bit            pf;
        bit            m;
        for (int c = 0; c < CH; c++) begin
            k    = cd[4*c +: 4];
            f    = fd[FW*c +: FW];
            g    = cf[3*c +: 3];
            ones = $countones(f);
`ifdef S15850_PRED_PARITY_EN
            pf = (ones % 2) == 1;
`else
            pf = 1'b0;
`endif
            if (k == 4'd0)  m = 1'b0;
            else if (k[3])  m = (ones == FW) && g[1] && !pf;
            else            m = (ones == 0) && g[0];
            h[c] = m ^ g[2];
            p[c] = pf;
        end
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < CH; c++) cnt_m[c] = 0;
        any_m = 1'b0;
    endfunction

    // One cycle: inputs already driven after the falling edge; check, then clock the model.
    task automatic step();
        logic          exp_ir;
        logic          exp_ov;
        logic          in_fire;
        logic          out_fire;
        logic          clr;
        logic [CH-1:0] h;
        logic [CH-1:0] p;
        beat_t         b;
        #1;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = (q.size() > 0) && (edge_cnt >= q[0].e + 1);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("hit", hit, q[0].h);
            chk("par", par, q[0].p);
        end
        for (int c = 0; c < CH; c++) chk("cnt", cnt[c*CNT_W +: CNT_W], cnt_m[c]);
        chk("any_hit", any_hit, any_m);
        in_fire  = in_valid && exp_ir;
        out_fire = exp_ov && out_ready;
        clr      = clr_cnt;
        predict(code, field, cfg, h, p);
        @(posedge CK);
        edge_cnt++;
        if (out_fire) begin
            b = q.pop_front();
            n_out++;
            if (!clr) begin
                for (int c = 0; c < CH; c++)
                    if (b.h[c] && cnt_m[c] < CMAX) cnt_m[c]++;
                if (|b.h) any_m = 1'b1;
            end
        end
        if (clr) clear_model();
        if (in_fire) begin
            b.h = h;
            b.p = p;
            b.e = edge_cnt;
            q.push_back(b);
        end
        @(negedge CK);
    endtask

    task automatic rand_inputs();
        int r;
        for (int c = 0; c < CH; c++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      code[4*c +: 4] = 4'd0;
            else if (r == 1) code[4*c +: 4] = 4'(4'h8 | $urandom_range(0, 7));
            else             code[4*c +: 4] = 4'($urandom_range(1, 7));
            r = $urandom_range(0, 9);
            if (r < 3)      field[FW*c +: FW] = '0;
            else if (r < 6) field[FW*c +: FW] = '1;
            else            field[FW*c +: FW] = FW'($urandom);
            cfg[3*c +: 3] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        repeat (3) step();
    endtask

    // Present one beat into an empty pipe; returns with its result on the output.
    task automatic send(input logic [3:0] c0, input logic [FW-1:0] f0, input logic [2:0] g0,
                        input logic [3:0] c1, input logic [FW-1:0] f1, input logic [2:0] g1);
        in_valid  = 1'b1;
        code      = {c1, c0};
        field     = {f1, f0};
        cfg       = {g1, g0};
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        step();
        in_valid = 1'b0;
        #1 chk("lat_t1", out_valid, 1'b0);
        step();
        #1 chk("lat_t2", out_valid, 1'b1);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        #2 RST = 1'b1;
        #1;
        q.delete();
        clear_model();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt", cnt, 0);
        chk("rst_any_hit", any_hit, 1'b0);
        @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
    endtask

    initial begin
        int stalled;
        int sent;
        int out0;
        RST       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        code      = '0;
        field     = '0;
        cfg       = '0;
        clear_model();
        repeat (2) @(negedge CK);
        RST = 1'b0;
        #1;
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_hit", hit, 0);
        chk("init_cnt", cnt, 0);
        step();

        // Directed classification cases.
        send(4'd0, 4'h0, 3'b000, 4'd0, 4'h0, 3'b000);
        chk("idle_pol0", hit, 2'b00);
        step();
        send(4'd0, 4'h0, 3'b100, 4'd0, 4'h0, 3'b100);
        chk("idle_pol1", hit, 2'b11);
        step();
        send(4'b1000, 4'hF, 3'b010, 4'b0010, 4'h0, 3'b001);
        chk("hi_lo_match", hit, 2'b11);
        chk("hi_par", par[0], 1'b0);
        step();
        send(4'b1000, 4'h1, 3'b010, 4'b0010, 4'h1, 3'b001);
        chk("field1_nomatch", hit, 2'b00);
        step();
        drain();

        // Backpressure: five beats, output stalled for four cycles.
        stalled = 0;
        sent    = 0;
        out0    = n_out;
        for (int i = 0; i < 12; i++) begin
            in_valid  = (sent < 5);
            rand_inputs();
            out_ready = !(i >= 2 && i <= 5);
            clr_cnt   = 1'b0;
            #1;
            if (in_valid && !in_ready) stalled++;
            if (in_valid && in_ready) sent++;
            step();
        end
        drain();
        chk("bp_stall_seen", stalled > 0, 1'b1);
        chk("bp_all_out", n_out - out0, 5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_cnt   = ($urandom_range(0, 39) == 0);
            rand_inputs();
            step();
        end
        drain();

        // Saturation: ten accepted hits on channel 0 only.
        clr_cnt = 1'b1;
        step();
        clr_cnt  = 1'b0;
        in_valid = 1'b1;
        code     = '0;
        field    = '0;
        cfg      = {3'b000, 3'b100};
        repeat (10) step();
        drain();
        chk("sat_cnt0", cnt[0 +: CNT_W], 7);
        chk("sat_cnt1", cnt[CNT_W +: CNT_W], 0);
        chk("sat_any", any_hit, 1'b1);
        send(4'd0, 4'h0, 3'b100, 4'd0, 4'h0, 3'b000);
        step();
        #1 chk("sat_hold", cnt[0 +: CNT_W], 7);
        step();

        // Clear coinciding with an accepted hit.
        send(4'd0, 4'h0, 3'b100, 4'd0, 4'h0, 3'b100);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        #1;
        chk("clr_cnt", cnt, 0);
        chk("clr_any", any_hit, 1'b0);
        step();

        // Reset with two beats in flight.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        rand_inputs();
        step();
        step();
        chk("two_inflight", q.size(), 2);
        do_reset();
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clr_cnt   = 1'b0;
            rand_inputs();
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/s15850_pred_pipe.md
Name: s15850_pred_pipe

Overview:
- Parametrised, pipelined successor to the s15850 combinational predicate cones.
- Evaluates a per-channel state code and status field for CH channels in parallel.
- Two-stage valid/ready pipeline; per-channel saturating hit counters.
- Sits between the s15850 state-register bank and the downstream event logger.

Parameters:
- FW, 4: status-field width per channel (≥2).
- CH, 2: channel count (≥1).
- CNT_W, 8: hit-counter width per channel.

Ports:
- CK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- code  in  CH*4  per-channel state code; channel c uses bits [4c+3:4c]
- field  in  CH*FW  per-channel status field
- cfg  in  CH*3  per channel {pol, en_hi, en_lo}, with en_lo at bit 3c
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- hit  out  CH  per-channel predicate result
- par  out  CH  per-channel field parity (optional feature)
- clr_cnt  in  1  synchronous counter clear
- cnt  out  CH*CNT_W  per-channel saturating hit counts
- any_hit  out  1  sticky: some hit bit was accepted since the last reset or clear

Behaviour:
- Reset: all pipeline valids 0; hit, par, cnt, any_hit all 0; in_ready 1 on the first cycle after RST deasserts.
- Classification per channel, stage 1, registered:
  - code==0 -> IDLE.
  - code[3]==1 -> HI.
  - otherwise -> LO.
  - Register the class, fz=(field==0), fo=(&field), pol, en_hi, en_lo.
- Predicate, stage 2, registered:
  - match = HI ? (fo&en_hi) : LO ? (fz&en_lo) : 0.
  - hit = match^pol. IDLE with pol=1 gives hit=1.
- Latency: a beat accepted in cycle t appears at the output in cycle t+2 when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - Each stage holds its data while its valid is set and it cannot advance.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = (!s1_valid || s2 advances). This is a combinational path from out_ready.
  - in_valid is ignored while in_ready=0. No beat is dropped or duplicated.
- Outputs: hit, par and out_valid are stable while out_valid && !out_ready.
- Counters:
  - On output acceptance, cnt[c] increments by 1 where hit[c]=1.
  - Counters saturate at 2^CNT_W-1 with no wrap.
  - any_hit is set on acceptance if |hit.
- Clear:
  - clr_cnt zeroes all cnt and any_hit next edge.
  - If an acceptance coincides with clr_cnt, the clear wins; that beat is not counted.
- Mid-operation reset: in-flight beats are discarded and counters are zeroed asynchronously.

Optional Feature:
- Macro: S15850_PRED_PARITY_EN.
- Defined:
  - par[c] = ^field[c], registered in stage 1 and forwarded through stage 2 alongside hit.
  - In HI class, match additionally requires par=0.
- Undefined: par is tied 0 and the predicate is as above. Port list is unchanged.

Decomposition:
- Package s15850_pred_pkg holds:
  - the class enum {IDLE, LO, HI} as 2 bits;
  - the cfg bit-index constants;
  - a function classify(code).
- One sub-module, s15850_pred_lane: the per-channel stage-1/stage-2 datapath plus counter, instantiated CH times by generate.
- The pipeline valid/ready control stays in the top level, shared by all lanes.

Test Plan:
- Reset and idle:
  - RST pulse mid-stream with 2 beats in flight -> out_valid=0 next cycle, cnt=0, in_ready=1.
  - Code=0, field=0, cfg=3'b000 -> hit=0. With cfg=3'b100 -> hit=1.
- HI/LO match, FW=4, CH=2:
  - ch0 code=4'b1000, field=4'hF, cfg=3'b010 -> hit[0]=1 at t+2.
  - ch1 code=4'b0010, field=4'h0, cfg=3'b001 -> hit[1]=1.
  - field=4'h1 on either channel -> hit=0.
- Backpressure:
  - Stream 5 beats with out_ready low for cycles 3–6 -> in_ready falls when both stages are full.
  - All 5 results emerge in order, unchanged while stalled; none dropped.
- Saturation: CNT_W=3, 10 accepted hits on ch0 -> cnt[0]=7 and stays at 7.
- Clear collision: clr_cnt asserted in the same cycle as an accepted hit -> cnt=0, any_hit=0 next cycle.
- Parity, with S15850_PRED_PARITY_EN defined:
  - HI, field=4'hF, en_hi=1 -> par=0, hit=1.
  - FW=5, field=5'h1F -> par=1, hit=0.
  - Without the macro: par=0 and hit=1 for the FW=5 case.
